// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one instruction-memory request at a time and
// buffers returned words in a 2-entry queue for decode, with flush/redirect support.
module instr_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          QDEPTH     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_e;

  localparam logic [1:0] QD = 2'(QDEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_pending_q, pc_pending_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [31:0] pc_mem_q    [QDEPTH];
  logic [31:0] pc_mem_d    [QDEPTH];
  logic [31:0] instr_mem_q [QDEPTH];
  logic [31:0] instr_mem_d [QDEPTH];

  logic        slot_free;
  logic        req_on;
  logic        hs;
  logic        push;
  logic        pop;
  logic [1:0]  cnt_after_push;

  // A request may only be handed to memory while a queue slot is reserved for its reply.
  assign slot_free      = (cnt_q < QD);
  assign req_on         = (state_q == REQ) && slot_free;
  assign hs             = req_on && imem_req_ready;
  assign push           = (state_q == WAIT) && imem_resp_valid && !flush;
  assign pop            = (cnt_q != 2'd0) && if_ready;
  assign cnt_after_push = cnt_q + 2'd1 - {1'b0, pop};

  always_ff @(posedge clock or negedge reset) begin : state_reg
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!flush && slot_free) state_d = REQ;
      end
      REQ: begin
        if (hs)                         state_d = flush ? DROP : WAIT;
        else if (!flush && !slot_free)  state_d = IDLE;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          // A flushed response is thrown away, so the slot it reserved is free again.
          if (flush || (cnt_after_push < QD)) state_d = REQ;
          else                                state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_resp_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : outputs
    imem_req_valid = req_on;
    imem_addr      = (state_q == REQ) ? pc_in : pc_pending_q;
    pc_advance     = hs && !flush;
    if_valid       = (cnt_q != 2'd0);
    if_pc          = pc_mem_q[rd_ptr_q];
    if_instr       = instr_mem_q[rd_ptr_q];
  end

  always_comb begin : queue_next
    pc_pending_d = hs ? pc_in : pc_pending_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    pc_mem_d     = pc_mem_q;
    instr_mem_d  = instr_mem_q;
    if (flush) begin
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = pc_pending_q;
        instr_mem_d[wr_ptr_q] = imem_resp_data;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock or negedge reset) begin : queue_reg
    if (!reset) begin
      pc_pending_q <= RESET_ADDR;
      cnt_q        <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        pc_mem_q[i]    <= RESET_ADDR;
        instr_mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      pc_pending_q <= pc_pending_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      pc_mem_q     <= pc_mem_d;
      instr_mem_q  <= instr_mem_d;
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset) push |-> (cnt_q < QD));
  a_adv_on_hs:   assert property (@(posedge clock) disable iff (!reset) pc_advance |-> hs);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic against a
// transaction-level model of the PC register, instruction memory and decode queue.
module tb_instr_fetch;
  localparam logic [31:0] RST_ADDR = 32'hBFC0_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  instr_fetch #(.RESET_ADDR(RST_ADDR), .QDEPTH(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .pc_in           (pc_in),
    .pc_advance      (pc_advance),
    .flush           (flush),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        mem_busy = 1'b0;
  logic        mem_disc = 1'b0;
  logic [31:0] mem_addr = '0;
  int          mem_dly = 0;
  logic        rand_mode = 1'b0;
  logic        flush_on_resp = 1'b0;
  int          lat_cfg = 1;
  logic [31:0] flush_tgt = '0;
  logic        prev_rv = 1'b0, prev_hs = 1'b0, prev_fl = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        s_rst, s_rv, s_adv, s_ifv, s_hs, s_fl, s_resp;
  logic [31:0] s_addr, s_ifp, s_ifi;
  int          n_pop = 0;
  int          idle_cnt = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hAAAA_0001 ^ {a[17:0], 14'h0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: sample at the falling edge, update the model, drive after the rising edge.
  task automatic step();
    logic pop;
    ent_t e;
    @(negedge clock);
    s_rst  = reset;
    s_rv   = imem_req_valid;
    s_adv  = pc_advance;
    s_ifv  = if_valid;
    s_addr = imem_addr;
    s_ifp  = if_pc;
    s_ifi  = if_instr;
    s_fl   = flush;
    s_resp = imem_resp_valid;
    s_hs   = s_rv & imem_req_ready;
    pop    = s_ifv & if_ready;
    if (!s_rst) begin
      exp_q.delete();
      if (mem_busy) mem_disc = 1'b1;
      if (s_resp) mem_busy = 1'b0;
      prev_rv = 1'b0; prev_hs = 1'b0; prev_fl = 1'b0;
      idle_cnt = 0;
    end else begin
      chk("if_valid", 32'(s_ifv), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("if_pc", s_ifp, exp_q[0].pc);
        chk("if_instr", s_ifi, exp_q[0].instr);
      end
      chk("pc_advance", 32'(s_adv), 32'(s_hs & ~s_fl));
      if (s_rv) chk("imem_addr", s_addr, pc_in);
      if (s_hs) begin
        chk("one_outstanding", 32'(mem_busy), 32'd0);
        chk("reserved_slot", 32'(exp_q.size() <= 1), 32'd1);
      end
      if (prev_rv && !prev_hs && !prev_fl) begin
        chk("req_hold", 32'(s_rv), 32'd1);
        chk("addr_hold", s_addr, prev_addr);
      end
      if (s_hs || pop || s_resp) idle_cnt = 0;
      else idle_cnt++;
      if (idle_cnt > 40) begin
        chk("stall", 32'(idle_cnt), 32'd0);
        idle_cnt = 0;
      end
      if (pop) begin
        n_pop++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_resp) begin
        if (!mem_disc && !s_fl) begin
          e.pc    = mem_addr;
          e.instr = mem_word(mem_addr);
          exp_q.push_back(e);
        end
        mem_busy = 1'b0;
      end
      if (s_hs) begin
        mem_busy = 1'b1;
        mem_disc = 1'b0;
        mem_addr = s_addr;
        mem_dly  = rand_mode ? int'($urandom_range(1, 3)) : lat_cfg;
      end
      if (s_fl) begin
        exp_q.delete();
        if (mem_busy) mem_disc = 1'b1;
      end
      prev_rv = s_rv; prev_hs = s_hs; prev_fl = s_fl; prev_addr = s_addr;
    end
    @(posedge clock);
    #1;
    if (s_rst) begin
      if (s_fl)       pc_in = flush_tgt;
      else if (s_adv) pc_in = pc_in + 32'd4;
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (mem_busy) begin
      mem_dly--;
      if (mem_dly <= 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mem_addr);
      end
    end
    if (rand_mode) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 19) == 0);
      flush_tgt      = $urandom & 32'h0000_FFFC;
    end else begin
      flush = 1'b0;
    end
    if (flush_on_resp && imem_resp_valid) begin
      flush         = 1'b1;
      if_ready      = 1'b1;
      flush_on_resp = 1'b0;
    end
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    reset = 1'b0;
    flush = 1'b0;
    pc_in = start_pc;
    repeat (4) step();
    reset = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_pc_advance"}, 32'(pc_advance), 32'd0);
    chk({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, RST_ADDR);
    chk({tag, "_if_pc"}, if_pc, RST_ADDR);
    chk({tag, "_if_instr"}, if_instr, 32'h0000_0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic bad;
    int   adv_cnt;
    int   hs_cnt;

    reset = 1'b1; pc_in = '0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; if_ready = 1'b0;
    #1 reset = 1'b0;
    #1 chk_reset_outputs("rst");

    // First fetch from address 0 with single-cycle memory.
    imem_req_ready = 1'b1; if_ready = 1'b1; lat_cfg = 1; pc_in = '0;
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("first_req_delay", 32'(s_rv), 32'd0);
    adv_cnt = 0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_ifv) found = 1'b1;
      else adv_cnt += int'(s_adv);
    end
    chk("t036_valid_seen", 32'(found), 32'd1);
    chk("t036_if_pc", s_ifp, 32'h0000_0000);
    chk("t036_if_instr", s_ifi, 32'hAAAA_0001);
    chk("t036_adv_pulses", 32'(adv_cnt), 32'd1);

    // Decode stalled: only two fetches may be accepted.
    imem_req_ready = 1'b1; if_ready = 1'b0; lat_cfg = 1;
    do_reset(32'h0);
    hs_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      hs_cnt += int'(s_hs);
    end
    chk("t037_accepts", 32'(hs_cnt), 32'd2);
    chk("t037_no_req", 32'(s_rv), 32'd0);
    chk("t037_head_pc", s_ifp, 32'h0);
    chk("t037_pc_in", pc_in, 32'h8);
    if_ready = 1'b1;
    step();
    if_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      found = s_hs;
    end
    chk("t037_refetch_seen", 32'(found), 32'd1);
    chk("t037_refetch_addr", s_addr, 32'h8);

    // Memory not ready for five cycles.
    imem_req_ready = 1'b0; if_ready = 1'b1; lat_cfg = 1;
    do_reset(32'h40);
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      step();
      found = s_rv;
    end
    chk("t040_req_seen", 32'(found), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t040_valid_hold", 32'(s_rv), 32'd1);
      chk("t040_addr_hold", s_addr, 32'h40);
      chk("t040_no_adv", 32'(s_adv), 32'd0);
    end
    imem_req_ready = 1'b1;
    step();
    chk("t040_adv_pulse", 32'(s_adv), 32'd1);
    chk("t040_accept_addr", s_addr, 32'h40);
    step();
    chk("t040_single_pulse", 32'(s_adv), 32'd0);

    // Redirect while waiting on a slow response.
    imem_req_ready = 1'b1; if_ready = 1'b1; lat_cfg = 3;
    do_reset(32'h10);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      found = s_hs;
    end
    chk("t038_req_addr", s_addr, 32'h10);
    flush = 1'b1; flush_tgt = 32'h100;
    step();
    found = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_ifv) bad = 1'b1;
      found = s_hs;
    end
    chk("t038_no_valid", 32'(bad), 32'd0);
    chk("t038_new_req_seen", 32'(found), 32'd1);
    chk("t038_new_addr", s_addr, 32'h100);

    // Flush coincident with a response and a pop at count 1.
    imem_req_ready = 1'b1; if_ready = 1'b0; lat_cfg = 2; flush_tgt = 32'h400;
    do_reset(32'h200);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      found = s_ifv;
    end
    chk("t039_one_queued", 32'(found), 32'd1);
    flush_on_resp = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step();
      found = s_fl & s_resp;
    end
    chk("t039_flush_on_resp", 32'(found), 32'd1);
    step();
    chk("t039_cleared", 32'(s_ifv), 32'd0);
    flush_on_resp = 1'b0;

    // Asynchronous reset in the middle of an outstanding request.
    imem_req_ready = 1'b1; if_ready = 1'b1; lat_cfg = 3;
    do_reset(32'h300);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      step();
      found = s_hs;
    end
    chk("t041_req_seen", 32'(found), 32'd1);
    #1 reset = 1'b0;
    #1 chk_reset_outputs("t041");
    repeat (4) step();
    reset = 1'b1;

    // Randomized traffic.
    rand_mode = 1'b1;
    n_pop = 0;
    for (int i = 0; i < 3000; i++) step();
    chk("throughput", 32'(n_pop >= 150), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
